// File: rtl/axi_slave_wr_ctrl.sv
// AXI write-channel slave that turns single-ID write bursts into word writes on a simple SRAM port.
// Optional macro WR_BURST_CHECK_EN flags malformed bursts with a SLVERR response.
module axi_slave_wr_ctrl #(
   parameter int unsigned MEM_ADDR_BITS = 14
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [7:0]               AWID_S,
   input  logic [31:0]              AWADDR,
   input  logic [3:0]               AWLEN,
   input  logic [2:0]               AWSIZE,
   input  logic [1:0]               AWBURST,
   input  logic                     AWVALID,
   output logic                     AWREADY,
   input  logic [31:0]              WDATA,
   input  logic [3:0]               WSTRB,
   input  logic                     WLAST,
   input  logic                     WVALID,
   output logic                     WREADY,
   output logic [7:0]               BID_S,
   output logic [1:0]               BRESP,
   output logic                     BVALID,
   input  logic                     BREADY,
   output logic                     mem_cs,
   output logic [3:0]               mem_we,
   output logic [MEM_ADDR_BITS-1:0] mem_addr,
   output logic [31:0]              mem_di
);

   typedef enum logic [1:0] {StIdle, StData, StResp} state_e;

   state_e                   state_q, state_d;
   logic                     awready_q, awready_d;
   logic                     wready_q, wready_d;
   logic                     bvalid_q, bvalid_d;
   logic [1:0]               bresp_q, bresp_d;
   logic [7:0]               id_q, id_d;
   logic [MEM_ADDR_BITS-1:0] addr_q, addr_d;
   logic [3:0]               len_q, len_d;
   logic [3:0]               cnt_q, cnt_d;
   logic                     fixed_q, fixed_d;
   logic                     err_q, err_d;

   logic aw_hs, w_hs, b_hs, last_beat, size_err, beat_err;

   assign aw_hs     = awready_q & AWVALID;
   assign w_hs      = wready_q & WVALID;
   assign b_hs      = bvalid_q & BREADY;
   assign last_beat = WLAST | (cnt_q == len_q);

`ifdef WR_BURST_CHECK_EN
   logic unused_addr;
   assign unused_addr = ^{AWADDR[1:0], AWADDR[31:MEM_ADDR_BITS+2]};
   assign size_err    = (AWSIZE != 3'b010);
   // Flags early WLAST as well as a missing WLAST on the final counted beat.
   assign beat_err    = WLAST ^ (cnt_q == len_q);
`else
   logic unused_in;
   assign unused_in = ^{AWADDR[1:0], AWADDR[31:MEM_ADDR_BITS+2], AWSIZE};
   assign size_err  = 1'b0;
   assign beat_err  = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      awready_d = awready_q;
      wready_d  = wready_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      id_d      = id_q;
      addr_d    = addr_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      fixed_d   = fixed_q;
      err_d     = err_q;
      unique case (state_q)
         StIdle: begin
            if (aw_hs) begin
               id_d      = AWID_S;
               addr_d    = AWADDR[MEM_ADDR_BITS+1:2];
               len_d     = AWLEN;
               fixed_d   = (AWBURST == 2'b00);
               cnt_d     = 4'd0;
               err_d     = size_err;
               awready_d = 1'b0;
               wready_d  = 1'b1;
               state_d   = StData;
            end
         end
         StData: begin
            if (w_hs) begin
               if (!fixed_q) addr_d = addr_q + MEM_ADDR_BITS'(1);
               cnt_d = cnt_q + 4'd1;
               err_d = err_q | beat_err;
               if (last_beat) begin
                  wready_d = 1'b0;
                  bvalid_d = 1'b1;
                  bresp_d  = (err_q | beat_err) ? 2'b10 : 2'b00;
                  state_d  = StResp;
               end
            end
         end
         StResp: begin
            if (b_hs) begin
               bvalid_d  = 1'b0;
               bresp_d   = 2'b00;
               awready_d = 1'b1;
               state_d   = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         awready_q <= 1'b1;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= 2'b00;
         id_q      <= 8'h00;
         addr_q    <= '0;
         len_q     <= 4'd0;
         cnt_q     <= 4'd0;
         fixed_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         id_q      <= id_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         fixed_q   <= fixed_d;
         err_q     <= err_d;
      end
   end

   assign AWREADY  = awready_q;
   assign WREADY   = wready_q;
   assign BVALID   = bvalid_q;
   assign BID_S    = id_q;
   assign BRESP    = bresp_q;
   // Memory strobes are purely a function of the live W handshake.
   assign mem_cs   = w_hs;
   assign mem_we   = w_hs ? WSTRB : 4'b0000;
   assign mem_di   = w_hs ? WDATA : 32'h0;
   assign mem_addr = addr_q;

endmodule

// File: tb/tb_axi_slave_wr_ctrl.sv
// Directed bench for axi_slave_wr_ctrl: inputs change 1ns after posedge, outputs checked 1ns later.
module tb_axi_slave_wr_ctrl;

   localparam int unsigned AB = 14;

   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    AWID_S;
   logic [31:0]   AWADDR;
   logic [3:0]    AWLEN;
   logic [2:0]    AWSIZE;
   logic [1:0]    AWBURST;
   logic          AWVALID, AWREADY;
   logic [31:0]   WDATA;
   logic [3:0]    WSTRB;
   logic          WLAST, WVALID, WREADY;
   logic [7:0]    BID_S;
   logic [1:0]    BRESP;
   logic          BVALID, BREADY;
   logic          mem_cs;
   logic [3:0]    mem_we;
   logic [AB-1:0] mem_addr;
   logic [31:0]   mem_di;

   int tests = 0;
   int fails = 0;

`ifdef WR_BURST_CHECK_EN
   localparam logic [1:0] ErrResp = 2'b10;
`else
   localparam logic [1:0] ErrResp = 2'b00;
`endif

   always #5 clk = ~clk;

   axi_slave_wr_ctrl #(.MEM_ADDR_BITS(AB)) dut (
      .clk(clk), .rst(rst),
      .AWID_S(AWID_S), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
      .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
      .BID_S(BID_S), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_di(mem_di)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle_chk(input string tag);
      settle();
      chk({tag, "_cs"}, 32'(mem_cs), 32'd0);
      chk({tag, "_we"}, 32'(mem_we), 32'd0);
   endtask

   task automatic do_aw(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                        input logic [1:0] burst, input logic [2:0] size);
      AWID_S = id; AWADDR = addr; AWLEN = len; AWBURST = burst; AWSIZE = size; AWVALID = 1'b1;
      settle();
      chk("aw_ready", 32'(AWREADY), 32'd1);
      chk("aw_wready", 32'(WREADY), 32'd0);
      tick();
      AWVALID = 1'b0;
   endtask

   task automatic beat(input logic [31:0] data, input logic [3:0] strb, input logic last,
                       input logic [AB-1:0] exp_addr);
      WDATA = data; WSTRB = strb; WLAST = last; WVALID = 1'b1;
      settle();
      chk("w_ready", 32'(WREADY), 32'd1);
      chk("w_cs", 32'(mem_cs), 32'd1);
      chk("w_we", 32'(mem_we), 32'(strb));
      chk("w_addr", 32'(mem_addr), 32'(exp_addr));
      chk("w_di", mem_di, data);
      tick();
      WVALID = 1'b0; WLAST = 1'b0;
   endtask

   task automatic do_resp(input logic [7:0] id, input logic [1:0] resp);
      settle();
      chk("b_valid", 32'(BVALID), 32'd1);
      chk("b_id", 32'(BID_S), 32'(id));
      chk("b_resp", 32'(BRESP), 32'(resp));
      chk("b_wready", 32'(WREADY), 32'd0);
      chk("b_cs", 32'(mem_cs), 32'd0);
      BREADY = 1'b1;
      tick();
      BREADY = 1'b0;
      settle();
      chk("b_done", 32'(BVALID), 32'd0);
      chk("b_awready", 32'(AWREADY), 32'd1);
   endtask

   initial begin
      rst = 1'b1; AWID_S = '0; AWADDR = '0; AWLEN = '0; AWSIZE = 3'b010; AWBURST = 2'b01;
      AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      settle();
      chk("rst_awready", 32'(AWREADY), 32'd1);
      chk("rst_wready", 32'(WREADY), 32'd0);
      chk("rst_bvalid", 32'(BVALID), 32'd0);
      chk("rst_bid", 32'(BID_S), 32'd0);
      chk("rst_bresp", 32'(BRESP), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      chk("rst_di", mem_di, 32'd0);

      // W presented while idle is ignored
      WVALID = 1'b1; WDATA = 32'hCAFEF00D; WSTRB = 4'hF; WLAST = 1'b1;
      settle();
      chk("idle_wready", 32'(WREADY), 32'd0);
      chk("idle_cs", 32'(mem_cs), 32'd0);
      chk("idle_we", 32'(mem_we), 32'd0);
      tick();
      WVALID = 1'b0; WLAST = 1'b0;

      // Single beat, minimum latency
      do_aw(8'h23, 32'h100, 4'd0, 2'b01, 3'b010);
      beat(32'hDEADBEEF, 4'hF, 1'b1, 14'h40);
      do_resp(8'h23, 2'b00);

      // INCR 4 beats with WVALID gaps
      tick();
      do_aw(8'h51, 32'h0, 4'd3, 2'b01, 3'b010);
      beat(32'h11111111, 4'hF, 1'b0, 14'd0);
      idle_chk("gap1");
      tick();
      beat(32'h22222222, 4'hF, 1'b0, 14'd1);
      idle_chk("gap2");
      tick();
      idle_chk("gap3");
      tick();
      beat(32'h33333333, 4'hF, 1'b0, 14'd2);
      beat(32'h44444444, 4'hF, 1'b1, 14'd3);
      do_resp(8'h51, 2'b00);

      // FIXED 3 beats, partial strobes
      tick();
      do_aw(8'h12, 32'h10, 4'd2, 2'b00, 3'b010);
      beat(32'hA5A5A5A5, 4'b0101, 1'b0, 14'd4);
      beat(32'h5A5A5A5A, 4'b0101, 1'b0, 14'd4);
      beat(32'h01234567, 4'b0101, 1'b1, 14'd4);
      do_resp(8'h12, 2'b00);

      // BREADY stalled 5 cycles with a pending AW
      tick();
      do_aw(8'hA7, 32'h20, 4'd0, 2'b01, 3'b010);
      beat(32'h0BADCAFE, 4'hF, 1'b1, 14'h8);
      AWID_S = 8'h3C; AWADDR = 32'h40; AWLEN = 4'd0; AWBURST = 2'b01; AWVALID = 1'b1;
      for (int i = 0; i < 5; i++) begin
         settle();
         chk("stall_bvalid", 32'(BVALID), 32'd1);
         chk("stall_bid", 32'(BID_S), 32'hA7);
         chk("stall_bresp", 32'(BRESP), 32'd0);
         chk("stall_awready", 32'(AWREADY), 32'd0);
         tick();
      end
      BREADY = 1'b1;
      settle();
      chk("bhs_awready", 32'(AWREADY), 32'd0);
      tick();
      BREADY = 1'b0;
      settle();
      chk("post_b_bvalid", 32'(BVALID), 32'd0);
      chk("post_b_awready", 32'(AWREADY), 32'd1);
      tick();
      AWVALID = 1'b0;
      beat(32'h77778888, 4'hF, 1'b1, 14'h10);
      do_resp(8'h3C, 2'b00);

      // Early WLAST on beat 2 of a 4-beat burst
      tick();
      do_aw(8'h66, 32'h80, 4'd3, 2'b01, 3'b010);
      beat(32'hAAAA0001, 4'hF, 1'b0, 14'h20);
      beat(32'hAAAA0002, 4'hF, 1'b1, 14'h21);
      do_resp(8'h66, ErrResp);

      // Unsupported AWSIZE
      tick();
      do_aw(8'h45, 32'h0C, 4'd0, 2'b01, 3'b000);
      beat(32'h13579BDF, 4'hF, 1'b1, 14'h3);
      do_resp(8'h45, ErrResp);

      // Reset after beat 1 of a 4-beat burst
      tick();
      do_aw(8'h77, 32'h200, 4'd3, 2'b01, 3'b010);
      beat(32'hBEEF0001, 4'hF, 1'b0, 14'h80);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      WVALID = 1'b1; WDATA = 32'hBEEF0002; WSTRB = 4'hF; WLAST = 1'b1; BREADY = 1'b1;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("ab_awready", 32'(AWREADY), 32'd1);
         chk("ab_wready", 32'(WREADY), 32'd0);
         chk("ab_bvalid", 32'(BVALID), 32'd0);
         chk("ab_bid", 32'(BID_S), 32'd0);
         chk("ab_cs", 32'(mem_cs), 32'd0);
         chk("ab_we", 32'(mem_we), 32'd0);
         chk("ab_addr", 32'(mem_addr), 32'd0);
         chk("ab_di", mem_di, 32'd0);
         tick();
      end
      WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
